// File: rtl/oam_dma_controller_pkg.sv
// Shared types and constants for the OAM DMA sequencer.
package oam_dma_controller_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    localparam int OAM_DMA_LEN   = 160;
    localparam int TCYC_PER_BYTE = 4;
    localparam int START_DELAY   = 4;

    localparam logic [7:0]  DMA_LAST_IDX   = 8'(OAM_DMA_LEN - 1);
    localparam logic [1:0]  DMA_LAST_PHASE = 2'(TCYC_PER_BYTE - 1);
    localparam logic [1:0]  DMA_DELAY_LAST = 2'(START_DELAY - 2);

    localparam logic [15:0] IO_GATE_BASE = 16'hFF00;
    localparam logic [15:0] DMA_OAM_ADDR = 16'hFF46;
    localparam logic [7:0]  MIRROR_BASE  = 8'hE0;
    localparam logic [7:0]  MIRROR_OFS   = 8'h20;

    // Echo RAM: E0xx..FFxx sources read from C0xx..DFxx.
    function automatic logic [7:0] mirror_hi(input logic [7:0] hi);
        return (hi >= MIRROR_BASE) ? hi - MIRROR_OFS : hi;
    endfunction

endpackage

// File: rtl/oam_dma_cpu_gate.sv
// Combinational CPU grant / read-data mux used while OAM DMA owns the bus.
module oam_dma_cpu_gate
    import oam_dma_controller_pkg::*;
(
    input  logic        dma_active,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_read_en,
    input  logic [7:0]  src_hi,
    input  logic [7:0]  blk_byte,
    output logic        cpu_grant,
    output logic [7:0]  cpu_rdata
);

    always_comb begin
        cpu_grant = 1'b1;
        cpu_rdata = 8'hFF;
        if (cpu_addr == DMA_OAM_ADDR) begin
            cpu_grant = 1'b0;
            if (cpu_read_en) cpu_rdata = src_hi;
        end else if (dma_active && cpu_addr < IO_GATE_BASE) begin
            cpu_grant = 1'b0;
            if (cpu_read_en) cpu_rdata = blk_byte;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: FF46 decode, 160-byte copy at one byte per M-cycle.
// OAM_DMA_BUS_CONFLICT_EN: blocked CPU reads return the last DMA byte.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_grant,
    output logic [15:0] mem_addr,
    output logic        mem_read_en,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write_en,
    output logic        dma_active
);

    dma_state_t  state_q, state_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  eff_hi_q, eff_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  dly_q, dly_d;
    logic        pend_q, pend_d;
    logic [7:0]  dbyte_q;
    logic [15:0] mem_addr_q;
    logic        mem_rd_q;
    logic [7:0]  oam_addr_q;
    logic        oam_we_q;
    logic        active_q;
    logic        ff46_wr;
    logic        xfer_d;
    logic [7:0]  blk_byte;

    assign ff46_wr = cpu_write_en && (cpu_addr == DMA_OAM_ADDR);
    assign xfer_d  = (state_d == DMA_XFER);

    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        eff_hi_d = eff_hi_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        dly_d    = dly_q;
        pend_d   = pend_q;
        if (state_q == DMA_XFER) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == DMA_LAST_PHASE) begin
                if (idx_q == DMA_LAST_IDX) begin
                    idx_d   = 8'd0;
                    state_d = (pend_q || ff46_wr) ? DMA_START : DMA_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
        end
        // A new write restarts the delay; the old copy runs on meanwhile.
        if (ff46_wr) begin
            src_hi_d = cpu_wdata;
            pend_d   = 1'b1;
            dly_d    = 2'd0;
            if (state_d == DMA_IDLE) state_d = DMA_START;
        end else if (pend_q) begin
            if (dly_q == DMA_DELAY_LAST) begin
                state_d  = DMA_XFER;
                eff_hi_d = mirror_hi(src_hi_q);
                idx_d    = 8'd0;
                phase_d  = 2'd0;
                pend_d   = 1'b0;
            end else begin
                dly_d = dly_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DMA_IDLE;
            src_hi_q   <= 8'h00;
            eff_hi_q   <= 8'h00;
            idx_q      <= 8'd0;
            phase_q    <= 2'd0;
            dly_q      <= 2'd0;
            pend_q     <= 1'b0;
            dbyte_q    <= 8'h00;
            mem_addr_q <= 16'h0000;
            mem_rd_q   <= 1'b0;
            oam_addr_q <= 8'd0;
            oam_we_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_hi_q   <= src_hi_d;
            eff_hi_q   <= eff_hi_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            dly_q      <= dly_d;
            pend_q     <= pend_d;
            if (mem_rd_q) dbyte_q <= mem_rdata;
            mem_rd_q   <= xfer_d && (phase_d == 2'd0);
            mem_addr_q <= xfer_d ? {eff_hi_d, idx_d} : 16'h0000;
            oam_we_q   <= xfer_d && (phase_d == 2'd1);
            oam_addr_q <= xfer_d ? idx_d : 8'd0;
            active_q   <= xfer_d;
        end
    end

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign blk_byte = dbyte_q;
`else
    assign blk_byte = 8'hFF;
`endif

    oam_dma_cpu_gate u_gate (
        .dma_active  (active_q),
        .cpu_addr    (cpu_addr),
        .cpu_read_en (cpu_read_en),
        .src_hi      (src_hi_q),
        .blk_byte    (blk_byte),
        .cpu_grant   (cpu_grant),
        .cpu_rdata   (cpu_rdata)
    );

    assign mem_addr     = mem_addr_q;
    assign mem_read_en  = mem_rd_q;
    assign oam_addr     = oam_addr_q;
    assign oam_wdata    = dbyte_q;
    assign oam_write_en = oam_we_q;
    assign dma_active   = active_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: CPU gate table plus DMA sequences.
module tb_oam_dma_controller;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic        cpu_grant;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write_en;
    logic        dma_active;

    logic [7:0]  sysmem [0:65535];
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    int          total;
    int          bad;

    typedef struct {
        string       name;
        logic        busy;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic        exp_grant;
        logic [7:0]  exp_rdata;
    } vec_t;

    oam_dma_controller dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read_en  (cpu_read_en),
        .cpu_write_en (cpu_write_en),
        .cpu_rdata    (cpu_rdata),
        .cpu_grant    (cpu_grant),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_rdata    (mem_rdata),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_write_en (oam_write_en),
        .dma_active   (dma_active)
    );

    assign mem_rdata = sysmem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oam_write_en) wq.push_back({oam_addr, oam_wdata});
        if (mem_read_en)  rq.push_back(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ff46(input logic [7:0] v);
        cpu_addr     = 16'hFF46;
        cpu_wdata    = v;
        cpu_write_en = 1'b1;
        tick();
        cpu_write_en = 1'b0;
        cpu_addr     = 16'h0000;
    endtask

    task automatic rd_ff46(input string nm, input logic [7:0] exp);
        cpu_addr    = 16'hFF46;
        cpu_read_en = 1'b1;
        #1;
        chk(nm, 32'(cpu_rdata), 32'(exp));
        cpu_read_en = 1'b0;
        cpu_addr    = 16'h0000;
    endtask

    task automatic wait_rd(input string nm, input logic [15:0] a);
        int n;
        n = 0;
        while (!(mem_read_en && mem_addr == a) && n < 2000) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (dma_active && n < 2000) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 2000), 32'd1);
    endtask

    task automatic apply_tab(input vec_t tab[], input logic busy);
        foreach (tab[i]) begin
            if (tab[i].busy == busy) begin
                cpu_addr     = tab[i].addr;
                cpu_read_en  = tab[i].rd;
                cpu_write_en = tab[i].wr;
                cpu_wdata    = 8'h33;
                #1;
                chk({tab[i].name, "_grant"}, 32'(cpu_grant),
                    32'(tab[i].exp_grant));
                chk({tab[i].name, "_rdata"}, 32'(cpu_rdata),
                    32'(tab[i].exp_rdata));
            end
        end
        cpu_addr     = 16'h0000;
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
    endtask

    initial begin
        vec_t        tab[];
        logic [7:0]  blk;
        logic [15:0] e;
        int          n;
        int          errs;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            sysmem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            sysmem[16'hC200 + 16'(i)] = 8'(i) + 8'h30;
            sysmem[16'hDE00 + 16'(i)] = ~8'(i);
        end
        sysmem[16'hC000] = 8'h77;
`ifdef OAM_DMA_BUS_CONFLICT_EN
        blk = 8'h14 ^ 8'h5A;
`else
        blk = 8'hFF;
`endif
        tab = new[11];
        tab[0]  = '{"idle_c000", 1'b0, 16'hC000, 1'b1, 1'b0, 1'b1, 8'hFF};
        tab[1]  = '{"idle_ff46", 1'b0, 16'hFF46, 1'b1, 1'b0, 1'b0, 8'h00};
        tab[2]  = '{"idle_ff80", 1'b0, 16'hFF80, 1'b1, 1'b0, 1'b1, 8'hFF};
        tab[3]  = '{"idle_wr",   1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 8'hFF};
        tab[4]  = '{"busy_c000", 1'b1, 16'hC000, 1'b1, 1'b0, 1'b0, blk};
        tab[5]  = '{"busy_8000", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, blk};
        tab[6]  = '{"busy_feff", 1'b1, 16'hFEFF, 1'b1, 1'b0, 1'b0, blk};
        tab[7]  = '{"busy_ff00", 1'b1, 16'hFF00, 1'b1, 1'b0, 1'b1, 8'hFF};
        tab[8]  = '{"busy_ff80", 1'b1, 16'hFF80, 1'b1, 1'b0, 1'b1, 8'hFF};
        tab[9]  = '{"busy_ff46", 1'b1, 16'hFF46, 1'b1, 1'b0, 1'b0, 8'hC1};
        tab[10] = '{"busy_wr",   1'b1, 16'hC000, 1'b0, 1'b1, 1'b0, 8'hFF};

        reset        = 1'b1;
        cpu_addr     = 16'h0000;
        cpu_wdata    = 8'h00;
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
        repeat (3) tick();
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_oam_we", 32'(oam_write_en), 32'd0);
        chk("rst_mem_rd", 32'(mem_read_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
        chk("rst_grant", 32'(cpu_grant), 32'd1);
        reset = 1'b0;
        tick();
        apply_tab(tab, 1'b0);

        // Basic copy from C100 with latency / length and gate checks.
        wq.delete();
        wr_ff46(8'hC1);
        n = 1;
        while (!dma_active && n < 10) begin
            tick();
            n++;
        end
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_first_rd", 32'(mem_read_en), 32'd1);
        chk("t1_first_addr", 32'(mem_addr), 32'hC100);
        n = 0;
        while (dma_active && n < 700) begin
            if (oam_write_en && oam_addr == 8'd20) apply_tab(tab, 1'b1);
            n++;
            tick();
        end
        chk("t1_active_len", 32'(n), 32'd640);
        chk("t1_wr_count", 32'(wq.size()), 32'd160);
        errs = 0;
        for (int i = 0; i < wq.size() && i < 160; i++)
            if (wq[i] != {8'(i), 8'(i) ^ 8'h5A}) errs++;
        chk("t1_oam_data", 32'(errs), 32'd0);

        // Restart at idx 50.
        wq.delete();
        wr_ff46(8'hC1);
        wait_rd("t3_wait_c132", 16'hC132);
        wr_ff46(8'hC2);
        repeat (3) tick();
        chk("t3_new_rd", 32'(mem_read_en), 32'd1);
        chk("t3_new_addr", 32'(mem_addr), 32'hC200);
        wait_idle("t3_done");
        tick();
        chk("t3_wr_count", 32'(wq.size()), 32'd211);
        errs = 0;
        for (int i = 0; i < wq.size() && i < 211; i++) begin
            if (i < 51) e = {8'(i), 8'(i) ^ 8'h5A};
            else e = {8'(i - 51), sysmem[16'hC200 + 16'(i - 51)]};
            if (wq[i] != e) errs++;
        end
        chk("t3_oam_data", 32'(errs), 32'd0);

        // Echo-RAM source FE -> DE.
        wq.delete();
        rq.delete();
        wr_ff46(8'hFE);
        rd_ff46("t4_ff46_start", 8'hFE);
        repeat (10) tick();
        rd_ff46("t4_ff46_busy", 8'hFE);
        wait_idle("t4_done");
        tick();
        chk("t4_rd_count", 32'(rq.size()), 32'd160);
        errs = 0;
        for (int i = 0; i < rq.size() && i < 160; i++)
            if (rq[i] != {8'hDE, 8'(i)}) errs++;
        chk("t4_rd_addrs", 32'(errs), 32'd0);
        errs = 0;
        for (int i = 0; i < wq.size() && i < 160; i++)
            if (wq[i] != {8'(i), ~8'(i)}) errs++;
        chk("t4_oam_data", 32'(errs), 32'd0);
        rd_ff46("t4_ff46_idle", 8'hFE);

        // Reset at idx 80.
        wq.delete();
        wr_ff46(8'hC1);
        wait_rd("t5_wait_c150", 16'hC150);
        reset = 1'b1;
        tick();
        chk("t5_oam_we", 32'(oam_write_en), 32'd0);
        chk("t5_active", 32'(dma_active), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("t5_wr_count", 32'(wq.size()), 32'd80);
        chk("t5_still_idle", 32'(dma_active), 32'd0);
        if (wq.size() > 0)
            chk("t5_last_wr", 32'(wq[wq.size() - 1]),
                32'({8'd79, 8'd79 ^ 8'h5A}));
        rd_ff46("t5_ff46_cleared", 8'h00);

        // FF46 write on the final clock of a transfer.
        wq.delete();
        wr_ff46(8'hC1);
        n = 0;
        while (!(oam_write_en && oam_addr == 8'd159) && n < 2000) begin
            tick();
            n++;
        end
        chk("t6_wait_last", 32'(n < 2000), 32'd1);
        repeat (2) tick();
        chk("t6_last_clk_active", 32'(dma_active), 32'd1);
        wr_ff46(8'hC2);
        chk("t6_gap", 32'(dma_active), 32'd0);
        chk("t6_wr_count", 32'(wq.size()), 32'd160);
        if (wq.size() >= 160)
            chk("t6_oam159", 32'(wq[159]),
                32'({8'd159, 8'd159 ^ 8'h5A}));
        repeat (3) tick();
        chk("t6_restart", 32'(dma_active), 32'd1);
        chk("t6_restart_addr", 32'(mem_addr), 32'hC200);
        wait_idle("t6_done");
        tick();
        chk("t6_total_wr", 32'(wq.size()), 32'd320);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
